// File: rtl/output_pkg.sv
// output_pkg: shared state type, default widths and derived lane constants for the output fetch path
package output_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int DEF_BUS_W = 128;
   localparam int DEF_LANE_W = 8;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_OUT_W = 16;
   localparam int DEF_FRAME_WORDS = 19200;
   localparam int DEF_DONE_DELAY = 12;
   localparam int DEF_LANES = DEF_BUS_W / DEF_LANE_W;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   localparam int DEF_LANE_IDX_W = idx_w(DEF_LANES);
endpackage

// File: rtl/output_fetch_unpacker_buffer.sv
// word_unpack_buffer: cur/pre word registers emitting one tagged lane per valid/ready handshake
module word_unpack_buffer
   import output_pkg::*;
#(
   parameter int BUS_W = DEF_BUS_W,
   parameter int LANE_W = DEF_LANE_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic wr_en,
   input  logic [BUS_W-1:0] wr_data,
   input  logic base_q,
   input  logic out_ready,
   output logic out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic pre_valid,
   output logic last_fire
);
   localparam int LANES = BUS_W / LANE_W;
   localparam int LW = idx_w(LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   logic [BUS_W-1:0] cur;
   logic [BUS_W-1:0] pre;
   logic [LW-1:0] lane;
   logic [LANE_W-1:0] lane_data;
   logic fire;
   logic to_cur;
   assign fire = out_valid && out_ready;
   assign last_fire = fire && lane == LAST_LANE;
   // a returning word bypasses pre whenever cur is free this cycle, keeping the stream gapless
   assign to_cur = !out_valid || (last_fire && !pre_valid);
   assign lane_data = LANE_W'(cur >> (int'(lane) * LANE_W));
   assign out_data = out_valid ? {base_q, {(OUT_W-1){1'b0}}} | OUT_W'(lane_data) : '0;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         cur <= '0;
         pre <= '0;
         out_valid <= 1'b0;
         pre_valid <= 1'b0;
         lane <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
         pre_valid <= 1'b0;
         lane <= '0;
      end else begin
         if (fire)
            lane <= last_fire ? '0 : lane + 1'b1;
         if (last_fire) begin
            cur <= pre;
            out_valid <= pre_valid;
            pre_valid <= 1'b0;
         end
         if (wr_en && to_cur) begin
            cur <= wr_data;
            out_valid <= 1'b1;
         end
         if (wr_en && !to_cur) begin
            pre <= wr_data;
            pre_valid <= 1'b1;
         end
      end
endmodule

// File: rtl/output_fetch_unpacker.sv
// output_fetch_unpacker: streams a frame of wide memory words out as base-tagged lane beats
module output_fetch_unpacker
   import output_pkg::*;
#(
   parameter int BUS_W = DEF_BUS_W,
   parameter int LANE_W = DEF_LANE_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int FRAME_WORDS = DEF_FRAME_WORDS,
   parameter int OUT_W = DEF_OUT_W,
   parameter int DONE_DELAY = DEF_DONE_DELAY
) (
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   input  logic base_sel,
   output logic rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [BUS_W-1:0] rd_data,
   output logic out_valid,
   input  logic out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic done
);
   localparam int DW = idx_w(DONE_DELAY);
   localparam logic [ADDR_W-1:0] N_WORDS = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-2:0] LAST_WORD = (ADDR_W-1)'(FRAME_WORDS - 1);
   localparam logic [DW-1:0] LAST_TICK = DW'(DONE_DELAY > 0 ? DONE_DELAY - 1 : 0);
   state_t state;
   state_t state_n;
   logic start_q;
   logic base_q;
   logic ret_q;
   logic issue;
   logic launch;
   logic pre_valid;
   logic last_fire;
   logic frame_end;
   logic [ADDR_W-1:0] issue_idx;
   logic [ADDR_W-2:0] word_idx;
   logic [DW-1:0] tick;
   assign launch = state == IDLE && start && !start_q;
   assign frame_end = last_fire && word_idx == LAST_WORD;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = launch ? RUN : IDLE;
         RUN: state_n = !start ? IDLE : !frame_end ? RUN : DONE_DELAY == 0 ? DONE : DRAIN;
         DRAIN: state_n = !start ? IDLE : tick == LAST_TICK ? DONE : DRAIN;
         default: state_n = start ? DONE : IDLE;
      endcase
   end
   // one read outstanding at most, and only into an empty pre slot, so no word is ever overwritten
   always_comb begin
      issue = state == RUN && start && !pre_valid && !rd_en && !ret_q && issue_idx < N_WORDS;
      done = state == DONE;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         start_q <= 1'b0;
         base_q <= 1'b0;
         rd_en <= 1'b0;
         rd_addr <= '0;
         ret_q <= 1'b0;
         issue_idx <= '0;
         word_idx <= '0;
         tick <= '0;
      end else begin
         start_q <= start;
         rd_en <= issue;
         ret_q <= rd_en && start;
         tick <= state == DRAIN ? tick + 1'b1 : '0;
         if (launch) begin
            base_q <= base_sel;
            issue_idx <= '0;
            word_idx <= '0;
         end
         if (issue) begin
            rd_addr <= {base_q, issue_idx[ADDR_W-2:0]};
            issue_idx <= issue_idx + 1'b1;
         end
         if (last_fire)
            word_idx <= word_idx + 1'b1;
      end
   word_unpack_buffer #(
      .BUS_W(BUS_W),
      .LANE_W(LANE_W),
      .OUT_W(OUT_W)
   ) u_buf (
      .clock(clock),
      .reset_n(reset_n),
      .clear(!start),
      .wr_en(ret_q && state == RUN),
      .wr_data(rd_data),
      .base_q(base_q),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .pre_valid(pre_valid),
      .last_fire(last_fire)
   );
endmodule

// File: tb/tb_output_fetch_unpacker.sv
// tb_output_fetch_unpacker: scoreboard bench over a 4-word frame unit and a narrow 1-word frame unit
module tb_output_fetch_unpacker;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [63:0] pat = 64'hB4E1_9C3A_5F06_D2A7;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name, input logic [63:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got %0h, expected no transfer", name, act);
   endtask

   logic a_start = 1'b0, a_base = 1'b0, a_ready = 1'b0;
   logic a_rd_en, a_valid, a_done;
   logic [15:0] a_addr;
   logic [15:0] a_data;
   logic [127:0] a_rd_data = '0;
   logic [15:0] a_exp[$];
   logic [15:0] a_aexp[$];

   output_fetch_unpacker #(
      .BUS_W(128), .LANE_W(8), .ADDR_W(16), .FRAME_WORDS(4), .OUT_W(16), .DONE_DELAY(12)
   ) dut_a (
      .clock(clock), .reset_n(reset_n), .start(a_start), .base_sel(a_base),
      .rd_en(a_rd_en), .rd_addr(a_addr), .rd_data(a_rd_data),
      .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .done(a_done)
   );

   logic b_start = 1'b0, b_base = 1'b0, b_ready = 1'b0;
   logic b_rd_en, b_valid, b_done;
   logic [15:0] b_addr;
   logic [16:0] b_data;
   logic [63:0] b_rd_data = '0;
   logic [16:0] b_exp[$];
   logic [15:0] b_aexp[$];

   output_fetch_unpacker #(
      .BUS_W(64), .LANE_W(16), .ADDR_W(16), .FRAME_WORDS(1), .OUT_W(17), .DONE_DELAY(0)
   ) dut_b (
      .clock(clock), .reset_n(reset_n), .start(b_start), .base_sel(b_base),
      .rd_en(b_rd_en), .rd_addr(b_addr), .rd_data(b_rd_data),
      .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .done(b_done)
   );

   function automatic logic [127:0] word_a(input logic [15:0] addr);
      logic [127:0] w;
      for (int k = 0; k < 16; k++) w[k*8 +: 8] = 8'(int'(addr[14:0]) * 16 + k);
      return w;
   endfunction

   function automatic logic [63:0] word_b(input logic [15:0] addr);
      logic [63:0] w;
      for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'('hA5C0 + int'(addr[14:0]) * 4 + k);
      return w;
   endfunction

   always @(posedge clock) a_rd_data <= a_rd_en ? word_a(a_addr) : '1;
   always @(posedge clock) b_rd_data <= b_rd_en ? word_b(b_addr) : '1;

   logic a_pv = 1'b0, a_pr = 1'b0;
   logic [15:0] a_pd = '0;
   int a_beats = 0, a_last_hs = 0, a_first_v = -1;
   always @(negedge clock) begin
      if (a_pv && !a_pr && a_valid) check("a_stall_stable", a_data, a_pd);
      if (a_valid && a_first_v < 0) a_first_v = cyc;
      if (a_valid && a_ready) begin
         a_beats++;
         a_last_hs = cyc + 1;
         if (a_exp.size() == 0) miss("a_beat", a_data);
         else check("a_beat", a_data, a_exp.pop_front());
      end
      if (a_rd_en) begin
         if (a_aexp.size() == 0) miss("a_rd_addr", a_addr);
         else check("a_rd_addr", a_addr, a_aexp.pop_front());
      end
      a_pv = a_valid;
      a_pr = a_ready;
      a_pd = a_data;
   end

   logic b_pv = 1'b0, b_pr = 1'b0;
   logic [16:0] b_pd = '0;
   int b_last_hs = 0, b_first_v = -1;
   always @(negedge clock) begin
      if (b_pv && !b_pr && b_valid) check("b_stall_stable", b_data, b_pd);
      if (b_valid && b_first_v < 0) b_first_v = cyc;
      if (b_valid && b_ready) begin
         b_last_hs = cyc + 1;
         if (b_exp.size() == 0) miss("b_beat", b_data);
         else check("b_beat", b_data, b_exp.pop_front());
      end
      if (b_rd_en) begin
         if (b_aexp.size() == 0) miss("b_rd_addr", b_addr);
         else check("b_rd_addr", b_addr, b_aexp.pop_front());
      end
      b_pv = b_valid;
      b_pr = b_ready;
      b_pd = b_data;
   end

   // mode 0: ready held high, 1: ready from pattern, 2: abort mid word 2, 3: reset during drain
   task automatic a_run(input logic base, input int mode);
      int n;
      int t0;
      for (int w = 0; w < 4; w++) begin
         a_aexp.push_back({base, 15'(w)});
         for (int k = 0; k < 16; k++) a_exp.push_back({base, 7'd0, 8'(w * 16 + k)});
      end
      @(posedge clock);
      #1;
      a_first_v = -1;
      a_beats = 0;
      a_base = base;
      a_start = 1'b1;
      a_ready = 1'b1;
      t0 = cyc + 1;
      n = 0;
      while (a_exp.size() != 0 && n < 3000 && !(mode == 2 && a_beats >= 37)) begin
         @(posedge clock);
         #1;
         a_ready = mode == 1 ? pat[n % 64] : 1'b1;
         n++;
      end
      a_ready = 1'b1;
      check("a_first_valid_latency", 64'(a_first_v - t0), 3);
      if (mode == 2) begin
         a_start = 1'b0;
         a_ready = 1'b0;
         @(posedge clock);
         repeat (6) begin
            @(negedge clock);
            check("a_abort_valid", a_valid, 0);
            check("a_abort_rd_en", a_rd_en, 0);
            check("a_abort_done", a_done, 0);
         end
         check("a_abort_beats", a_beats, 37);
         a_exp.delete();
         a_aexp.delete();
         return;
      end
      check("a_all_beats", a_exp.size(), 0);
      if (mode == 3) begin
         repeat (4) @(posedge clock);
         #2 reset_n = 1'b0;
         #1;
         check("a_rst_rd_en", a_rd_en, 0);
         check("a_rst_rd_addr", a_addr, 0);
         check("a_rst_valid", a_valid, 0);
         check("a_rst_data", a_data, 0);
         check("a_rst_done", a_done, 0);
         a_start = 1'b0;
         @(posedge clock);
         #1 reset_n = 1'b1;
         check("a_rst_reads", a_aexp.size(), 0);
         return;
      end
      n = 0;
      while (!a_done && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("a_done_seen", a_done, 1);
      check("a_done_delay", 64'(cyc - a_last_hs), 12);
      repeat (3) begin
         @(negedge clock);
         check("a_done_hold", a_done, 1);
      end
      @(posedge clock);
      #1 a_start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("a_done_release", a_done, 0);
      check("a_reads_done", a_aexp.size(), 0);
   endtask

   task automatic b_run(input logic base, input int mode);
      int n;
      int t0;
      b_aexp.push_back({base, 15'd0});
      for (int k = 0; k < 4; k++) b_exp.push_back({base, 16'('hA5C0 + k)});
      @(posedge clock);
      #1;
      b_first_v = -1;
      b_base = base;
      b_start = 1'b1;
      b_ready = 1'b1;
      t0 = cyc + 1;
      n = 0;
      while (b_exp.size() != 0 && n < 500) begin
         @(posedge clock);
         #1;
         b_ready = mode == 1 ? pat[n % 64] : 1'b1;
         n++;
      end
      b_ready = 1'b1;
      check("b_all_beats", b_exp.size(), 0);
      check("b_first_valid_latency", 64'(b_first_v - t0), 3);
      n = 0;
      while (!b_done && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("b_done_seen", b_done, 1);
      check("b_done_delay", 64'(cyc - b_last_hs), 0);
      repeat (3) begin
         @(negedge clock);
         check("b_done_hold", b_done, 1);
      end
      @(posedge clock);
      #1 b_start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("b_done_release", b_done, 0);
      check("b_reads_done", b_aexp.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check("a_reset_rd_en", a_rd_en, 0);
      check("a_reset_rd_addr", a_addr, 0);
      check("a_reset_valid", a_valid, 0);
      check("a_reset_data", a_data, 0);
      check("a_reset_done", a_done, 0);
      check("b_reset_rd_en", b_rd_en, 0);
      check("b_reset_rd_addr", b_addr, 0);
      check("b_reset_valid", b_valid, 0);
      check("b_reset_data", b_data, 0);
      check("b_reset_done", b_done, 0);
      reset_n = 1'b1;
      a_run(1'b1, 0);
      a_run(1'b1, 1);
      a_run(1'b1, 2);
      a_run(1'b0, 0);
      a_run(1'b1, 3);
      a_run(1'b1, 0);
      b_run(1'b1, 1);
      b_run(1'b0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/output_fetch_unpacker.md
Name: output_fetch_unpacker

Overview:
Parametrised frame read-out engine for the output pipeline. It streams FRAME_WORDS wide words from the output frame buffer, starting at one of two base halves, and unpacks each word into LANE_W-bit lanes. Lanes leave on a valid/ready stream with the base bit tagged in the MSB of every beat. It is a double-buffered successor to the single-word output fetch stage: it adds backpressure, configurable widths and frame length, and a programmable done delay that covers downstream pipeline depth.

Parameters:
BUS_W, 128, read bus width in bits; must be a multiple of LANE_W
LANE_W, 8, bits per output lane (pixel)
ADDR_W, 16, read address width; MSB is the base select, lower ADDR_W-1 bits are the word index
FRAME_WORDS, 19200, words per frame; 1 to 2^(ADDR_W-1)
OUT_W, 16, output beat width; must be at least LANE_W+1
DONE_DELAY, 12, cycles from last lane accepted to done asserting; 0 or more

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level run enable; deasserting aborts the frame
base_sel  in  1  frame-buffer half; sampled on start rising edge
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  {base_q, word index}
rd_data  in  BUS_W  read data, valid exactly 1 cycle after rd_en
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  {base_q, zeros, lane}
done  out  1  frame complete; level, held while start is high

Behaviour:
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, done=0, all counters 0, FSM in IDLE.
- LANES=BUS_W/LANE_W. Lane k = rd_data[k*LANE_W +: LANE_W]. Lane 0 leaves first, then ascending order.
- A beat transfers when out_valid & out_ready. While out_valid=1 and no transfer occurs, out_data must stay stable.
- FSM IDLE: on start rising edge, latch base_q=base_sel, clear word index, lane count and done counter, go to RUN.
- FSM RUN:
  - Storage is two word registers: cur and pre, each with a valid flag.
  - Issue a read (rd_en=1 for one cycle, rd_addr={base_q, issue_idx}) when all hold: pre is empty, no read is in flight, issue_idx < FRAME_WORDS. Increment issue_idx after each read.
  - The returning word writes pre, or writes cur directly if cur is empty.
  - On the handshake of lane LANES-1, move pre into cur in the same cycle. With pre valid this gives zero-bubble streaming at 1 lane per cycle when out_ready is held high.
  - When the last lane of word FRAME_WORDS-1 transfers, go to DRAIN.
- FSM DRAIN: count DONE_DELAY cycles, then go to DONE. With DONE_DELAY=0, go straight to DONE.
- FSM DONE: done=1, no reads, out_valid=0. Stay here until start falls, then return to IDLE with done=0.
- start low in any state except IDLE: next cycle go to IDLE. Set out_valid=0, clear both buffer valid flags, and drop any in-flight return. No beat may be emitted after the abort edge.
- Latency: first out_valid is 3 cycles after the start rising edge (IDLE→RUN, read issue, data return).
- base_sel changes mid-frame are ignored; only base_q is used.
- Address arithmetic: the index is ADDR_W-1 bits and never wraps, because issue stops at FRAME_WORDS.
- reset_n asserted mid-frame: immediate return to reset values.

Decomposition:
- Shared package output_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE)
  - default widths (BUS_W, LANE_W, ADDR_W, OUT_W)
  - the FRAME_WORDS default
  - the derived constant LANES and the lane-index width $clog2(LANES)
- One natural sub-module, word_unpack_buffer: the cur/pre registers, lane counter, lane mux and valid/ready handshake. The top level keeps the FSM, address generation and the done counter.

Test Plan:
- Reset then start=1, base_sel=1, FRAME_WORDS=4, out_ready=1, memory word n = bytes n*16+k → rd_addr 0x8000..0x8003, 64 beats, out_data 0x8000..0x803F with no gaps, done=1 exactly 12 cycles after the last beat.
- Same run with out_ready toggled by a random 50% pattern → identical beat sequence, out_data stable while stalled, no extra reads (pre is never overwritten).
- Drop start mid-word 2 → out_valid=0 next cycle, no further rd_en, done stays 0. Restart with base_sel=0 → addresses begin at 0x0000 and lane 0 of word 0 comes first.
- FRAME_WORDS=1, DONE_DELAY=0 → 16 beats, done asserted the cycle after the last handshake, held until start falls.
- Parameter set BUS_W=64, LANE_W=16, OUT_W=17 → 4 beats per word, ordering lane0→lane3, MSB of out_data = base_q.
- Assert reset_n during DRAIN → all outputs 0 immediately. The next start runs a full frame correctly.
